// File: rtl/game_sequencer_if.sv
// game_sequencer_if: level selection, play-logic results and game status
// exchanged between the game controller and its neighbours.
interface game_sequencer_if;
   logic [2:0] level;
   logic       level_valid;
   logic       hit;
   logic       miss;
   logic [2:0] speed;
   logic [4:0] target_count;
   logic       spawn;
   logic [4:0] remaining;
   logic [4:0] score;
   logic [4:0] misses;
   logic       game_active;
   logic       game_done;
   logic       pass;
   logic       level_err;

   // Drives level selection and hit/miss results, observes game status
   modport master (
      output level, level_valid, hit, miss,
      input  speed, target_count, spawn, remaining, score, misses,
             game_active, game_done, pass, level_err
   );

   // The game controller itself
   modport slave (
      input  level, level_valid, hit, miss,
      output speed, target_count, spawn, remaining, score, misses,
             game_active, game_done, pass, level_err
   );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: latches the difficulty, paces object spawns, tallies
// hit/miss results against outstanding objects and declares pass/fail.
module game_sequencer #(
   parameter int BASE_PERIOD = 1_000_000,
   parameter int MAX_MISS    = 3
) (
   input  logic            clk,
   input  logic            rst,
   game_sequencer_if.slave bus
);
   localparam int TW = $clog2(BASE_PERIOD);

   typedef enum logic [2:0] {IDLE, LOAD, PLAY, DRAIN, DONE} state_t;

   state_t        state;
   logic [2:0]    speed;
   logic [4:0]    target_count;
   logic          spawn;
   logic [4:0]    remaining;
   logic [4:0]    score;
   logic [4:0]    misses;
   logic          game_active;
   logic          game_done;
   logic          pass;
   logic          level_err;
   logic [TW-1:0] tick;
   logic [TW-1:0] period_m1;
   logic [4:0]    spawned;

   logic          level_ok;
   logic          in_game;
   logic [5:0]    resolved;
   logic [5:0]    resolved_next;
   logic [5:0]    outstanding;
   logic          accept_hit;
   logic          accept_miss;
   logic          fail_now;
   logic [4:0]    score_next;
   logic [4:0]    misses_next;
   logic [4:0]    remaining_next;
   logic [TW-1:0] tick_next;

   // Acceptance rules: results only count against objects already launched
   // (a spawn in the same cycle is not yet outstanding); with a single
   // outstanding object a simultaneous hit wins over the miss.
   always_comb begin
      level_ok       = (bus.level == 3'b001) || (bus.level == 3'b010) ||
                       (bus.level == 3'b100);
      in_game        = (state == PLAY) || (state == DRAIN);
      resolved       = {1'b0, score} + {1'b0, misses};
      outstanding    = {1'b0, spawned} - resolved;
      accept_hit     = in_game && bus.hit && (outstanding >= 6'd1);
      accept_miss    = in_game && bus.miss &&
                       (outstanding >= (bus.hit ? 6'd2 : 6'd1));
      score_next     = score + {4'd0, accept_hit};
      misses_next    = misses + {4'd0, accept_miss};
      resolved_next  = {1'b0, score_next} + {1'b0, misses_next};
      fail_now       = accept_miss && (misses_next == 5'(MAX_MISS));
      tick_next      = (tick == period_m1) ? '0 : tick + TW'(1);
      remaining_next = (spawn && (remaining != 5'd0)) ? remaining - 5'd1 : remaining;
   end

   // Game FSM with all status outputs registered alongside the state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         speed        <= '0;
         target_count <= '0;
         spawn        <= 1'b0;
         remaining    <= '0;
         score        <= '0;
         misses       <= '0;
         game_active  <= 1'b0;
         game_done    <= 1'b0;
         pass         <= 1'b0;
         level_err    <= 1'b0;
         tick         <= '0;
         period_m1    <= '0;
         spawned      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.level_valid) begin
                  if (level_ok) begin
                     level_err <= 1'b0;
                     state     <= LOAD;
                     case (bus.level)
                        3'b001: begin
                           speed        <= 3'd1;
                           target_count <= 5'd8;
                           period_m1    <= TW'(BASE_PERIOD - 1);
                        end
                        3'b010: begin
                           speed        <= 3'd2;
                           target_count <= 5'd12;
                           period_m1    <= TW'(BASE_PERIOD / 2 - 1);
                        end
                        default: begin
                           speed        <= 3'd4;
                           target_count <= 5'd16;
                           period_m1    <= TW'(BASE_PERIOD / 4 - 1);
                        end
                     endcase
                  end else begin
                     level_err <= 1'b1;
                  end
               end
            end
            LOAD: begin
               remaining   <= target_count;
               score       <= '0;
               misses      <= '0;
               tick        <= '0;
               spawned     <= '0;
               game_active <= 1'b1;
               // A one-cycle period spawns in the very first PLAY cycle
               spawn       <= (period_m1 == '0);
               state       <= PLAY;
            end
            PLAY: begin
               score     <= score_next;
               misses    <= misses_next;
               tick      <= tick_next;
               remaining <= remaining_next;
               if (spawn) begin
                  spawned <= spawned + 5'd1;
               end
               if (fail_now) begin
                  state       <= DONE;
                  game_active <= 1'b0;
                  game_done   <= 1'b1;
                  pass        <= 1'b0;
                  spawn       <= 1'b0;
               end else if (spawn && (remaining_next == 5'd0)) begin
                  state <= DRAIN;
                  spawn <= 1'b0;
               end else begin
                  spawn <= (tick_next == period_m1);
               end
            end
            DRAIN: begin
               score  <= score_next;
               misses <= misses_next;
               if (fail_now) begin
                  state       <= DONE;
                  game_active <= 1'b0;
                  game_done   <= 1'b1;
                  pass        <= 1'b0;
               end else if (resolved_next == {1'b0, target_count}) begin
                  state       <= DONE;
                  game_active <= 1'b0;
                  game_done   <= 1'b1;
                  pass        <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.speed        = speed;
   assign bus.target_count = target_count;
   assign bus.spawn        = spawn;
   assign bus.remaining    = remaining;
   assign bus.score        = score;
   assign bus.misses       = misses;
   assign bus.game_active  = game_active;
   assign bus.game_done    = game_done;
   assign bus.pass         = pass;
   assign bus.level_err    = level_err;
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Game controller that sits downstream of the keypad level-selection block.
- Latches the selected difficulty and converts it to a speed multiplier and an object count. Easy: x1 speed, 8 objects. Medium: x2, 12. Hard: x4, 16.
- Paces object spawns, tallies hit/miss results from the play logic, and declares pass/fail.
- The rest of the game datapath is enabled only while this block reports active play.

Parameters:
- BASE_PERIOD, 1_000_000: clk cycles between spawns at x1. Must be divisible by 4 and ≥ 4. Benches use 8.
- MAX_MISS, 3: miss count that ends the game early as a fail. Range 1..16.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous assert, active-low; clears all state
- level  in  3  one-hot difficulty {hard,mid,easy}
- level_valid  in  1  level-selection complete; level is stable while high
- hit  in  1  one-cycle pulse: oldest outstanding object was hit
- miss  in  1  one-cycle pulse: oldest outstanding object was missed
- speed  out  3  latched multiplier: 1, 2 or 4; 0 before load
- target_count  out  5  latched object count: 8, 12 or 16; 0 before load
- spawn  out  1  one-cycle pulse: launch next object
- remaining  out  5  objects not yet spawned
- score  out  5  accepted hits
- misses  out  5  accepted misses
- game_active  out  1  high in PLAY and DRAIN
- game_done  out  1  high in DONE
- pass  out  1  valid when game_done=1: 1 = finished with misses < MAX_MISS
- level_err  out  1  level_valid=1 seen with level not exactly one-hot

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - All outputs go to 0.
  - Tick counter, spawned count and resolved count go to 0.
- All registers update on the rising edge of clk.
- States: IDLE, LOAD, PLAY, DRAIN, DONE.
- IDLE:
  - If level_valid=1 and level ∈ {001,010,100}: clear level_err, go to LOAD.
  - If level_valid=1 and level is any other value: set level_err=1 and stay in IDLE. level_err holds until a valid load or reset.
- LOAD (exactly 1 cycle):
  - Latch speed and target_count: 001→1/8, 010→2/12, 100→4/16.
  - period = BASE_PERIOD / speed.
  - remaining = target_count; score, misses, tick and spawned all = 0.
  - Go to PLAY.
- After LOAD, changes on level and level_valid are ignored until reset.
- PLAY:
  - Tick counter counts 0..period-1, then wraps.
  - spawn=1 in the cycle where tick = period-1. In that cycle, remaining decrements and spawned increments.
  - First spawn occurs period cycles after the LOAD cycle, i.e. in the period-th PLAY cycle.
  - When remaining reaches 0 (takes effect on the spawn edge), go to DRAIN.
  - spawn never fires outside PLAY.
- Outstanding objects = spawned − (score + misses).
- Hit/miss acceptance (PLAY and DRAIN only):
  - A pulse is accepted only if outstanding ≥ 1; otherwise it is dropped silently.
  - hit and miss in the same cycle:
    - outstanding ≥ 2: both are accepted.
    - outstanding = 1: hit is accepted, miss is dropped.
  - A spawn in the same cycle does not count toward that cycle's outstanding.
- Early fail: if an accepted miss makes misses = MAX_MISS, go to DONE with pass=0 on that edge. This applies in PLAY or DRAIN; remaining spawns are abandoned.
- DRAIN: when score + misses = target_count, go to DONE with pass=1 (misses < MAX_MISS is guaranteed at that point).
- DONE:
  - game_done=1, game_active=0.
  - All counters frozen; hit/miss ignored.
  - Only reset leaves DONE.
- game_active and game_done are registered state decodes. They change on the same edge as the state.
- Counter widths: 5 bits is sufficient (max 16). No wrap can occur; the implementation must not allow remaining to underflow below 0.

Test Plan (BASE_PERIOD=8, MAX_MISS=3):
1. Easy full game: level=001, level_valid=1 → speed=1, target=8. Spawns are 8 cycles apart; answer every spawn with a hit 2 cycles later. After the 8th hit → game_done=1, pass=1, score=8, misses=0, remaining=0.
2. Hard pacing: level=100 → speed=4, target=16, spawns every 2 cycles. Exactly 16 spawn pulses; DRAIN is entered on the edge after the 16th spawn; game_active=1 throughout PLAY and DRAIN.
3. Early fail: level=010, miss on each of the first 3 spawns → game_done=1, pass=0 on the 3rd accepted miss. No further spawn; remaining=9.
4. Guards:
   - hit pulse before any spawn → score stays 0.
   - One outstanding object, hit and miss in the same cycle → score=1, misses=0.
   - Two outstanding objects, hit and miss in the same cycle → score+1 and misses+1.
5. Invalid level: level=011 with level_valid=1 → level_err=1, stays in IDLE, speed=0. Then level=001 → level_err=0, enters LOAD.
6. Mid-game reset: assert rst=0 mid-PLAY between clock edges → all outputs 0 immediately (async). Release, then a new level_valid starts a fresh game with correct first-spawn timing.
